// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the D-stage branch sequencer: comparator op codes,
// FSM state encodings and the operand-readiness helper.
package branch_ctrl_pkg;

  localparam logic [2:0] CMP_none = 3'd0;
  localparam logic [2:0] CMP_beq  = 3'd1;
  localparam logic [2:0] CMP_bne  = 3'd2;
  localparam logic [2:0] CMP_blez = 3'd3;

  typedef enum logic [1:0] {
    BC_IDLE = 2'd0,
    BC_WAIT = 2'd1,
    BC_DONE = 2'd2
  } bc_state_e;

  // blez compares rs against zero, so rt readiness is irrelevant for it.
  function automatic logic ops_ready(input logic rs_ready, input logic rt_ready,
                                     input logic [2:0] op);
    return rs_ready & (rt_ready | (op == CMP_blez));
  endfunction

endpackage

// File: rtl/branch_stat_cnt.sv
// Three enable-gated free-running statistics counters (resolved, taken,
// stall cycles); wrap modulo 2^CNT_W and clear on reset.
module branch_stat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_br,
  input  logic             inc_taken,
  input  logic             inc_stall,
  output logic [CNT_W-1:0] stat_br,
  output logic [CNT_W-1:0] stat_taken,
  output logic [CNT_W-1:0] stat_stall
);

  logic [2:0]            inc;
  logic [2:0][CNT_W-1:0] cnt_q;

  assign inc = {inc_stall, inc_taken, inc_br};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (inc[gi]) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      assign cnt_q[gi] = cnt_reg;
    end
  endgenerate

  assign stat_br    = cnt_q[0];
  assign stat_taken = cnt_q[1];
  assign stat_stall = cnt_q[2];

endmodule

// File: rtl/branch_ctrl.sv
// D-stage branch sequencer: waits for forwarded operands, drives the comparator,
// and issues a one-cycle redirect in the delay-slot cycle.
// Optional statistics counters are built when BRANCH_CTRL_STAT_EN is defined.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 3,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             D_br_valid,
  input  logic [2:0]       D_cmp_op,
  input  logic             D_rs_ready,
  input  logic             D_rt_ready,
  input  logic [31:0]      D_rs_val,
  input  logic [31:0]      D_rt_val,
  input  logic [31:0]      D_target,
  input  logic             ext_stall,
  input  logic             cmp_result,
  output logic [31:0]      cmp_A,
  output logic [31:0]      cmp_B,
  output logic [2:0]       cmp_op,
  output logic             br_stall,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             err,
  output logic [CNT_W-1:0] stat_br,
  output logic [CNT_W-1:0] stat_taken,
  output logic [CNT_W-1:0] stat_stall
);

  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  bc_state_e   state_reg, state_next;
  logic        taken_reg, taken_next;
  logic [31:0] tgt_reg, tgt_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic        err_reg, err_next;

  logic ops_ok;
  logic active;
  logic resolve;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= BC_IDLE;
      taken_reg    <= 1'b0;
      tgt_reg      <= '0;
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      taken_reg    <= taken_next;
      tgt_reg      <= tgt_next;
      wait_cnt_reg <= wait_cnt_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    ops_ok   = ops_ready(D_rs_ready, D_rt_ready, D_cmp_op);
    active   = (state_reg == BC_IDLE) || (state_reg == BC_WAIT);
    resolve  = D_br_valid & ops_ok & ~ext_stall & active;
    br_stall = D_br_valid & ~ops_ok & (state_reg != BC_DONE);

    cmp_A  = '0;
    cmp_B  = '0;
    cmp_op = CMP_none;
    if (D_br_valid && active) begin
      cmp_A  = D_rs_val;
      cmp_B  = D_rt_val;
      cmp_op = D_cmp_op;
    end

    state_next    = state_reg;
    taken_next    = taken_reg;
    tgt_next      = tgt_reg;
    wait_cnt_next = wait_cnt_reg;
    err_next      = err_reg;

    case (state_reg)
      BC_IDLE: begin
        if (resolve) begin
          state_next    = BC_DONE;
          taken_next    = cmp_result;
          tgt_next      = D_target;
          wait_cnt_next = '0;
        end else if (D_br_valid && !ops_ok) begin
          state_next    = BC_WAIT;
          wait_cnt_next = WAIT_W'(1);
        end
      end
      BC_WAIT: begin
        if (resolve) begin
          state_next    = BC_DONE;
          taken_next    = cmp_result;
          tgt_next      = D_target;
          wait_cnt_next = '0;
        end else if (!D_br_valid) begin
          state_next    = BC_IDLE;
          wait_cnt_next = '0;
        end else if (wait_cnt_reg == WAIT_W'(MAX_WAIT)) begin
          // Hazard timeout is flagged but the branch keeps waiting.
          if (!ops_ok) begin
            err_next = 1'b1;
          end
        end else begin
          wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
      end
      BC_DONE: begin
        // A branch sitting in the delay slot is illegal and is not executed.
        if (D_br_valid) begin
          err_next = 1'b1;
        end
        if (!ext_stall) begin
          state_next = BC_IDLE;
        end
      end
      default: begin
        state_next    = BC_IDLE;
        wait_cnt_next = '0;
      end
    endcase
  end

  // Redirect comes purely from registered state, so it is glitch-free and
  // naturally held while the pipeline is frozen in DONE.
  assign redirect    = (state_reg == BC_DONE) & taken_reg;
  assign redirect_pc = redirect ? tgt_reg : 32'd0;
  assign err         = err_reg;

`ifdef BRANCH_CTRL_STAT_EN
  branch_stat_cnt #(
    .CNT_W(CNT_W)
  ) u_stat (
    .clk       (clk),
    .reset     (reset),
    .inc_br    (resolve),
    .inc_taken (resolve & cmp_result),
    .inc_stall (br_stall),
    .stat_br   (stat_br),
    .stat_taken(stat_taken),
    .stat_stall(stat_stall)
  );
`else
  assign stat_br    = '0;
  assign stat_taken = '0;
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl; a small behavioural comparator
// answers the DUT's compare requests.
module tb_branch_ctrl;
  import branch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        D_br_valid;
  logic [2:0]  D_cmp_op;
  logic        D_rs_ready, D_rt_ready;
  logic [31:0] D_rs_val, D_rt_val, D_target;
  logic        ext_stall;
  logic        cmp_result;
  logic [31:0] cmp_A, cmp_B;
  logic [2:0]  cmp_op;
  logic        br_stall, redirect, err;
  logic [31:0] redirect_pc;
  logic [31:0] stat_br, stat_taken, stat_stall;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  branch_ctrl #(.MAX_WAIT(3), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .D_br_valid(D_br_valid), .D_cmp_op(D_cmp_op),
    .D_rs_ready(D_rs_ready), .D_rt_ready(D_rt_ready),
    .D_rs_val(D_rs_val), .D_rt_val(D_rt_val), .D_target(D_target),
    .ext_stall(ext_stall), .cmp_result(cmp_result),
    .cmp_A(cmp_A), .cmp_B(cmp_B), .cmp_op(cmp_op),
    .br_stall(br_stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .err(err), .stat_br(stat_br), .stat_taken(stat_taken), .stat_stall(stat_stall)
  );

  always_comb begin
    case (cmp_op)
      CMP_beq:  cmp_result = (cmp_A == cmp_B);
      CMP_bne:  cmp_result = (cmp_A != cmp_B);
      CMP_blez: cmp_result = ($signed(cmp_A) <= 0);
      default:  cmp_result = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) begin
      checks_passed++;
      $display("ok   %s: 0x%08h", tag, obs);
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic rsr, input logic rtr,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] tgt,
                       input logic xs);
    D_br_valid = v;  D_cmp_op = op;
    D_rs_ready = rsr; D_rt_ready = rtr;
    D_rs_val = rs;   D_rt_val = rt;   D_target = tgt;
    ext_stall = xs;
    #1;
  endtask

  task automatic idle;
    drive(1'b0, CMP_none, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Branch with rs held not-ready for nwait cycles, then resolved, then a DONE cycle.
  task automatic branch(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] tgt, input int nwait);
    for (int i = 0; i < nwait; i++) begin
      drive(1'b1, op, 1'b0, 1'b1, rs, rt, tgt, 1'b0);
      tick();
    end
    drive(1'b1, op, 1'b1, 1'b1, rs, rt, tgt, 1'b0);
    tick();
    idle();
    tick();
  endtask

  initial begin
    do_reset();
    check("rst_redirect", 32'(redirect), 32'd0);
    check("rst_pc", redirect_pc, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_stall", 32'(br_stall), 32'd0);
    check("rst_cmp_op", 32'(cmp_op), 32'(CMP_none));

    // beq taken, both ready
    drive(1'b1, CMP_beq, 1'b1, 1'b1, 32'h5, 32'h5, 32'h3010, 1'b0);
    check("beq_cmp_op", 32'(cmp_op), 32'(CMP_beq));
    check("beq_cmp_A", cmp_A, 32'h5);
    check("beq_stall", 32'(br_stall), 32'd0);
    check("beq_no_early_redirect", 32'(redirect), 32'd0);
    tick();
    idle();
    check("beq_redirect", 32'(redirect), 32'd1);
    check("beq_pc", redirect_pc, 32'h3010);
    check("done_cmp_op", 32'(cmp_op), 32'(CMP_none));
    tick();
    check("beq_redirect_drop", 32'(redirect), 32'd0);
    check("beq_pc_drop", redirect_pc, 32'd0);

    // bne not taken: visits DONE without redirect
    drive(1'b1, CMP_bne, 1'b1, 1'b1, 32'h7, 32'h7, 32'h4000, 1'b0);
    tick();
    idle();
    check("bne_redirect", 32'(redirect), 32'd0);
    check("bne_pc", redirect_pc, 32'd0);
    tick();

    // blez with rt not ready: no stall; cmp_op showing blez proves IDLE again
    drive(1'b1, CMP_blez, 1'b1, 1'b0, 32'h80000000, 32'hdead, 32'h5000, 1'b0);
    check("blez_cmp_op", 32'(cmp_op), 32'(CMP_blez));
    check("blez_stall", 32'(br_stall), 32'd0);
    check("blez_cmp_B", cmp_B, 32'hdead);
    tick();
    idle();
    check("blez_redirect", 32'(redirect), 32'd1);
    check("blez_pc", redirect_pc, 32'h5000);
    tick();

    // beq waits 2 cycles for rs
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, CMP_beq, 1'b0, 1'b1, 32'h9, 32'h9, 32'h6000, 1'b0);
      check($sformatf("wait2_stall%0d", i), 32'(br_stall), 32'd1);
      tick();
    end
    drive(1'b1, CMP_beq, 1'b1, 1'b1, 32'h9, 32'h9, 32'h6000, 1'b0);
    check("wait2_resolve_stall", 32'(br_stall), 32'd0);
    tick();
    idle();
    check("wait2_redirect", 32'(redirect), 32'd1);
    check("wait2_pc", redirect_pc, 32'h6000);
    check("wait2_err", 32'(err), 32'd0);
    tick();

    // beq waits 4 cycles: timeout err
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, CMP_beq, 1'b0, 1'b1, 32'h1, 32'h1, 32'h7000, 1'b0);
      check($sformatf("wait4_stall%0d", i), 32'(br_stall), 32'd1);
      tick();
    end
    drive(1'b1, CMP_beq, 1'b1, 1'b1, 32'h1, 32'h1, 32'h7000, 1'b0);
    check("wait4_err", 32'(err), 32'd1);
    tick();
    idle();
    check("wait4_redirect", 32'(redirect), 32'd1);
    check("wait4_pc", redirect_pc, 32'h7000);
    tick();
    check("err_sticky", 32'(err), 32'd1);
    do_reset();
    check("err_cleared", 32'(err), 32'd0);

    // ext_stall in IDLE blocks resolve without stalling
    drive(1'b1, CMP_beq, 1'b1, 1'b1, 32'h2, 32'h2, 32'h7700, 1'b1);
    check("xs_idle_stall", 32'(br_stall), 32'd0);
    tick();
    drive(1'b1, CMP_beq, 1'b1, 1'b1, 32'h2, 32'h2, 32'h7700, 1'b0);
    check("xs_idle_no_redirect", 32'(redirect), 32'd0);
    tick();
    idle();
    check("xs_idle_late_redirect", 32'(redirect), 32'd1);
    tick();

    // ext_stall held 2 cycles in DONE
    drive(1'b1, CMP_beq, 1'b1, 1'b1, 32'h4, 32'h4, 32'h8000, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, CMP_none, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, (i < 2));
      check($sformatf("hold_redirect%0d", i), 32'(redirect), 32'd1);
      check($sformatf("hold_pc%0d", i), redirect_pc, 32'h8000);
      tick();
    end
    idle();
    check("hold_release", 32'(redirect), 32'd0);

    // branch in delay slot
    drive(1'b1, CMP_beq, 1'b1, 1'b1, 32'h6, 32'h6, 32'h9000, 1'b0);
    tick();
    drive(1'b1, CMP_beq, 1'b1, 1'b1, 32'h3, 32'h3, 32'hA000, 1'b0);
    check("slot_redirect", 32'(redirect), 32'd1);
    check("slot_pc", redirect_pc, 32'h9000);
    check("slot_cmp_op", 32'(cmp_op), 32'(CMP_none));
    tick();
    idle();
    check("slot_err", 32'(err), 32'd1);
    check("slot_no_second", 32'(redirect), 32'd0);
    tick();
    check("slot_no_second_late", 32'(redirect), 32'd0);

    // reset while in WAIT
    do_reset();
    drive(1'b1, CMP_beq, 1'b0, 1'b1, 32'h1, 32'h1, 32'hB000, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    check("rwait_redirect", 32'(redirect), 32'd0);
    check("rwait_pc", redirect_pc, 32'd0);
    check("rwait_err", 32'(err), 32'd0);
    check("rwait_stall", 32'(br_stall), 32'd0);
    check("rwait_cmp_op", 32'(cmp_op), 32'(CMP_none));
    tick();
    check("rwait_no_late_redirect", 32'(redirect), 32'd0);

    // statistics: 5 resolves, 3 taken, 4 stall cycles
    do_reset();
    check("stat_br_rst", stat_br, 32'd0);
    branch(CMP_beq,  32'h5, 32'h5, 32'hC000, 2);
    branch(CMP_bne,  32'h1, 32'h2, 32'hC100, 0);
    branch(CMP_beq,  32'h1, 32'h2, 32'hC200, 0);
    branch(CMP_blez, 32'h0, 32'h9, 32'hC300, 0);
    branch(CMP_bne,  32'h3, 32'h3, 32'hC400, 2);
`ifdef BRANCH_CTRL_STAT_EN
    check("stat_br", stat_br, 32'd5);
    check("stat_taken", stat_taken, 32'd3);
    check("stat_stall", stat_stall, 32'd4);
`else
    check("stat_br_tied", stat_br, 32'd0);
    check("stat_taken_tied", stat_taken, 32'd0);
    check("stat_stall_tied", stat_stall, 32'd0);
`endif
    check("stat_run_err", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
